// File: rtl/serial_pkg.sv
// Shared types and default constants for the serial word assembler.
package serial_pkg;

    // Framing FSM: hunting for the sync pattern, or collecting data bits.
    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int         WORD_W_DEF   = 8;
    localparam int         SYNC_W_DEF   = 8;
    localparam logic [7:0] SYNC_PAT_DEF = 8'hA5;
    localparam int         FRAME_CNT_W  = 16;

endpackage

// File: rtl/serial_word_assembler_if.sv
// Serial input, word output handshake and status signals of the assembler.
// Handshake: a word transfers on every rising edge where out_valid & out_ready
// are both 1; out_valid never depends on out_ready in the same cycle, and
// out_data holds steady while out_valid=1 until that transfer happens.
interface serial_word_assembler_if
    import serial_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();
    logic                   bit_in;
    logic                   bit_en;
    logic                   out_ready;
    logic                   clear_err;
    logic [WORD_W-1:0]      out_data;
    logic                   out_valid;
    logic                   locked;
    logic                   overflow;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    state_t                 dbg_state;

    // Side that feeds bits and consumes words.
    modport master (
        output bit_in, bit_en, out_ready, clear_err,
        input  out_data, out_valid, locked, overflow, frame_cnt, dbg_state
    );

    // Assembler side.
    modport slave (
        input  bit_in, bit_en, out_ready, clear_err,
        output out_data, out_valid, locked, overflow, frame_cnt, dbg_state
    );
endinterface

// File: rtl/word_hold_reg.sv
// Single-entry valid/ready output register with sticky overflow and a
// count of words loaded.
module word_hold_reg
    import serial_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   complete_i,
    input  logic [WORD_W-1:0]      word_i,
    input  logic                   out_ready_i,
    input  logic                   clear_err_i,
    output logic [WORD_W-1:0]      out_data_o,
    output logic                   out_valid_o,
    output logic                   overflow_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);
    logic [WORD_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   drain;
    logic                   drop;

    // Load when empty or draining on this edge; otherwise a completed word is dropped.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        drain   = valid_q & out_ready_i;
        drop    = 1'b0;
        if (complete_i) begin
            if (!valid_q || drain) begin
                data_d  = word_i;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (drain) begin
            valid_d = 1'b0;
        end
        // A drop on the same edge as a clear leaves the flag set.
        if (clear_err_i) ovf_d = 1'b0;
        if (drop)        ovf_d = 1'b1;
    end

    // Hold register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;
    assign overflow_o  = ovf_q;
    assign frame_cnt_o = cnt_q;
endmodule

// File: rtl/serial_word_assembler.sv
// Hunts a serial bit stream for a sync pattern, then assembles the following
// WORD_W bits (MSB first) into a word handed to the output hold register.
module serial_word_assembler
    import serial_pkg::*;
#(
    parameter int                WORD_W   = WORD_W_DEF,
    parameter int                SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_W'(SYNC_PAT_DEF)
) (
    input logic                   clk,
    input logic                   rst_n,
    serial_word_assembler_if.slave bus
);
    localparam int HC_W = $clog2(SYNC_W + 1);
    localparam int BC_W = $clog2(WORD_W);
    localparam logic [HC_W-1:0] HUNT_FULL = HC_W'(SYNC_W);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(WORD_W - 1);

    state_t            state_q, state_d;
    logic [SYNC_W-1:0] sync_sr_q;
    logic [HC_W-1:0]   hunt_cnt_q;
    logic [WORD_W-1:0] data_sr_q;
    logic [BC_W-1:0]   bit_cnt_q;

    logic [SYNC_W-1:0] sync_shift;
    logic [HC_W-1:0]   hunt_inc;
    logic [WORD_W-1:0] word;
    logic              match;
    logic              complete;

    // Values after shifting in this edge's bit; match/complete include that bit.
    always_comb begin
        sync_shift = {sync_sr_q[SYNC_W-2:0], bus.bit_in};
        hunt_inc   = (hunt_cnt_q == HUNT_FULL) ? HUNT_FULL : hunt_cnt_q + 1'b1;
        word       = {data_sr_q[WORD_W-2:0], bus.bit_in};
        match      = bus.bit_en && (state_q == HUNT) && (hunt_inc == HUNT_FULL)
                     && (sync_shift == SYNC_PAT);
        complete   = bus.bit_en && (state_q == COLLECT) && (bit_cnt_q == LAST_BIT);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= HUNT;
        else        state_q <= state_d;
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        if (match)    state_d = COLLECT;
        if (complete) state_d = HUNT;
    end

    // FSM outputs, decoded from the state register only.
    always_comb begin
        bus.locked    = (state_q == COLLECT);
        bus.dbg_state = state_q;
    end

    // Shift registers and counters; frozen whenever bit_en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr_q  <= '0;
            hunt_cnt_q <= '0;
            data_sr_q  <= '0;
            bit_cnt_q  <= '0;
        end else if (bus.bit_en) begin
            if (state_q == HUNT) begin
                sync_sr_q  <= sync_shift;
                hunt_cnt_q <= hunt_inc;
                if (match) begin
                    data_sr_q <= '0;
                    bit_cnt_q <= '0;
                end
            end else begin
                data_sr_q <= word;
                if (complete) begin
                    // Back to HUNT: the next frame needs a full fresh sync pattern.
                    bit_cnt_q  <= '0;
                    sync_sr_q  <= '0;
                    hunt_cnt_q <= '0;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
            end
        end
    end

    word_hold_reg #(.WORD_W(WORD_W)) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .complete_i  (complete),
        .word_i      (word),
        .out_ready_i (bus.out_ready),
        .clear_err_i (bus.clear_err),
        .out_data_o  (bus.out_data),
        .out_valid_o (bus.out_valid),
        .overflow_o  (bus.overflow),
        .frame_cnt_o (bus.frame_cnt)
    );
endmodule
